// File: rtl/encoder_4to2.sv
// Registered 4-to-2 priority encoder (D[3] highest) with valid and multi-hot flags.
// Define ENCODER_4TO2_ERR_EN to add the saturating multi-hot counter err_cnt.
module encoder_4to2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] D,
    output logic [1:0] Y,
    output logic       valid,
    output logic       multi_hot
`ifdef ENCODER_4TO2_ERR_EN
    ,
    output logic [7:0] err_cnt
`endif
);

    // No handshake: D is sampled on every rising clk, and the outputs show that sample
    // one cycle later. Nothing can stall the pipe.
    logic [1:0] y_next;
    logic       valid_next;
    logic       multi_hot_next;

    always_comb begin
        y_next = 2'b00;
        casez (D)
            4'b1???: y_next = 2'b11;
            4'b01??: y_next = 2'b10;
            4'b001?: y_next = 2'b01;
            default: y_next = 2'b00;
        endcase
    end

    // Clearing the lowest set bit leaves a nonzero value only when two or more bits are set.
    always_comb begin
        valid_next     = |D;
        multi_hot_next = |(D & (D - 4'd1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Y         <= 2'b00;
            valid     <= 1'b0;
            multi_hot <= 1'b0;
        end else begin
            Y         <= y_next;
            valid     <= valid_next;
            multi_hot <= multi_hot_next;
        end
    end

`ifdef ENCODER_4TO2_ERR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt <= 8'h00;
        end else if (multi_hot_next && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'h01;
        end
    end
`endif

endmodule

// File: tb/tb_encoder_4to2.sv
// Bench for encoder_4to2: directed steps plus random D values, compared against a bit-scan model.
// Checks of the multi-hot counter are compiled in only when ENCODER_4TO2_ERR_EN is defined.
module tb_encoder_4to2;

    logic       clk;
    logic       rst;
    logic [3:0] D;
    logic [1:0] Y;
    logic       valid;
    logic       multi_hot;
`ifdef ENCODER_4TO2_ERR_EN
    logic [7:0] err_cnt;
`endif

    int total;
    int bad;
    int exp_err;

    encoder_4to2 dut (
        .clk       (clk),
        .rst       (rst),
        .D         (D),
        .Y         (Y),
        .valid     (valid),
        .multi_hot (multi_hot)
`ifdef ENCODER_4TO2_ERR_EN
        ,
        .err_cnt   (err_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: find the index of the highest set bit and count the set bits.
    task automatic model(input logic [3:0] d, output logic [1:0] e_y, output logic e_valid,
                         output logic e_multi);
        int idx;
        int ones;
        idx  = 0;
        ones = 0;
        for (int i = 0; i < 4; i++) begin
            if (d[i]) begin
                idx = i;
                ones++;
            end
        end
        e_y     = 2'(idx);
        e_valid = (ones > 0);
        e_multi = (ones > 1);
    endtask

    // Drive d, let one rising edge sample it, then check just after that edge.
    task automatic step(input logic [3:0] d, input string tag);
        logic [1:0] e_y;
        logic       e_valid;
        logic       e_multi;
        D = d;
        model(d, e_y, e_valid, e_multi);
        if (e_multi && exp_err < 255) exp_err++;
        @(posedge clk);
        #1;
        check({tag, ".Y"}, {6'd0, Y}, {6'd0, e_y});
        check({tag, ".valid"}, {7'd0, valid}, {7'd0, e_valid});
        check({tag, ".multi_hot"}, {7'd0, multi_hot}, {7'd0, e_multi});
`ifdef ENCODER_4TO2_ERR_EN
        check({tag, ".err_cnt"}, err_cnt, 8'(exp_err));
`endif
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".Y"}, {6'd0, Y}, 8'd0);
        check({tag, ".valid"}, {7'd0, valid}, 8'd0);
        check({tag, ".multi_hot"}, {7'd0, multi_hot}, 8'd0);
`ifdef ENCODER_4TO2_ERR_EN
        check({tag, ".err_cnt"}, err_cnt, 8'd0);
`endif
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        exp_err = 0;
        rst     = 1'b1;
        D       = 4'b0000;

        // Reset state with rst held across edges.
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;

        // One-hot sweep.
        step(4'b0001, "onehot0");
        step(4'b0010, "onehot1");
        step(4'b0100, "onehot2");
        step(4'b1000, "onehot3");

        // Multi-hot and zero.
        step(4'b0011, "multi_0011");
        step(4'b1110, "multi_1110");
        step(4'b0000, "zero");

        // Asynchronous reset mid-cycle while D=1000.
        step(4'b1000, "pre_rst");
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        exp_err = 0;
        @(posedge clk);
        #1;
        check_reset_outputs("rst_hold");
        rst = 1'b0;
        step(4'b0100, "post_rst");

        // Exhaustive sweep of all 16 values.
        for (int v = 0; v < 16; v++) begin
            step(4'(v), $sformatf("exh_%0d", v));
        end

        // Random stimulus.
        for (int n = 0; n < 200; n++) begin
            step(4'($urandom_range(0, 15)), $sformatf("rand_%0d", n));
        end

`ifdef ENCODER_4TO2_ERR_EN
        // Saturation: 300 cycles of all-ones must pin the counter at FF.
        for (int n = 0; n < 300; n++) begin
            step(4'b1111, "sat");
        end
        check("sat_final", err_cnt, 8'hFF);
        step(4'b0001, "sat_onehot");
        rst = 1'b1;
        #1;
        exp_err = 0;
        check("sat_clear", err_cnt, 8'h00);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(4'b0110, "after_clear");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
